// File: rtl/branch_resolve_unit.sv
// Branch resolve unit: in-order queue of predicted branches, resolution against
// execute outcomes, gshare training pulses, and flush/redirect on mispredict.
module branch_resolve_unit #(
    parameter int DEPTH        = 4,
    parameter int PC_W         = 32,
    parameter int IDX_W        = 8,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push_valid,
    output logic                       push_ready,
    input  logic [PC_W-1:0]            push_pc,
    input  logic                       push_pred_taken,
    input  logic [PC_W-1:0]            push_pred_target,
    input  logic                       res_valid,
    output logic                       res_ready,
    input  logic                       res_taken,
    input  logic [PC_W-1:0]            res_target,
    output logic                       update,
    output logic [IDX_W-1:0]           update_address,
    output logic                       branch_taken,
    output logic                       flush,
    output logic [PC_W-1:0]            redirect_pc,
    output logic [$clog2(DEPTH):0]     occupancy,
    output logic [15:0]                branch_cnt,
    output logic [15:0]                mispred_cnt
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(FLUSH_CYCLES + 1);

    typedef enum logic {RUN, RECOVER} state_t;

    typedef struct packed {
        logic [PC_W-1:0] pc;
        logic            pred_taken;
        logic [PC_W-1:0] pred_target;
    } entry_t;

    entry_t          q [DEPTH];
    entry_t          head_e;
    logic [AW-1:0]   head_ptr, tail_ptr;
    logic [AW:0]     count;
    state_t          state, state_nxt;
    logic [CW-1:0]   rec_cnt, rec_cnt_nxt;
    logic            full, empty, push_fire, res_fire, mispred;

    assign full       = (count == (AW+1)'(DEPTH));
    assign empty      = (count == '0);
    assign push_ready = (state == RUN) && !full;
    assign res_ready  = (state == RUN) && !empty && !update;
    assign push_fire  = push_valid && push_ready;
    assign res_fire   = res_valid && res_ready;
    assign head_e     = q[head_ptr];
    assign occupancy  = count;

    // A taken/taken match still mispredicts when the targets disagree.
    assign mispred = res_fire &&
                     ((head_e.pred_taken != res_taken) ||
                      (res_taken && (head_e.pred_target != res_target)));

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= RUN;
            rec_cnt <= '0;
        end else begin
            state   <= state_nxt;
            rec_cnt <= rec_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        rec_cnt_nxt = '0;
        case (state)
            RUN: begin
                if (mispred) state_nxt = RECOVER;
            end
            RECOVER: begin
                if (rec_cnt == CW'(FLUSH_CYCLES - 1)) state_nxt = RUN;
                else                                  rec_cnt_nxt = rec_cnt + CW'(1);
            end
            default: state_nxt = RUN;
        endcase
    end

    // Entry storage needs no reset; validity is tracked by the pointers.
    always_ff @(posedge clk) begin
        if (push_fire) q[tail_ptr] <= '{pc: push_pc, pred_taken: push_pred_taken,
                                        pred_target: push_pred_target};
    end

    // A mispredict squashes everything queued, including a same-cycle push.
    always_ff @(posedge clk) begin
        if (rst || mispred) begin
            head_ptr <= '0;
            tail_ptr <= '0;
            count    <= '0;
        end else begin
            if (push_fire) tail_ptr <= tail_ptr + AW'(1);
            if (res_fire)  head_ptr <= head_ptr + AW'(1);
            count <= count + (AW+1)'(push_fire) - (AW+1)'(res_fire);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            update         <= 1'b0;
            flush          <= 1'b0;
            update_address <= '0;
            branch_taken   <= 1'b0;
            redirect_pc    <= '0;
            branch_cnt     <= '0;
            mispred_cnt    <= '0;
        end else begin
            update <= res_fire;
            flush  <= mispred;
            if (res_fire) begin
                update_address <= head_e.pc[IDX_W+1:2];
                branch_taken   <= res_taken;
                if (branch_cnt != 16'hFFFF) branch_cnt <= branch_cnt + 16'd1;
            end
            if (mispred) begin
                redirect_pc <= res_taken ? res_target : head_e.pc + PC_W'(4);
                if (mispred_cnt != 16'hFFFF) mispred_cnt <= mispred_cnt + 16'd1;
            end
        end
    end
endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed bench for branch_resolve_unit: vector table of single-branch
// resolutions plus hand sequences for fill, squash, overlap and reset cases.
module tb_branch_resolve_unit;
    logic        clk = 1'b0;
    logic        rst;
    logic        push_valid, push_ready, push_pred_taken;
    logic [31:0] push_pc, push_pred_target;
    logic        res_valid, res_ready, res_taken;
    logic [31:0] res_target;
    logic        update, branch_taken, flush;
    logic [7:0]  update_address;
    logic [31:0] redirect_pc;
    logic [2:0]  occupancy;
    logic [15:0] branch_cnt, mispred_cnt;

    int checks = 0;
    int errors = 0;

    branch_resolve_unit #(.DEPTH(4), .PC_W(32), .IDX_W(8), .FLUSH_CYCLES(2)) dut (
        .clk(clk), .rst(rst),
        .push_valid(push_valid), .push_ready(push_ready), .push_pc(push_pc),
        .push_pred_taken(push_pred_taken), .push_pred_target(push_pred_target),
        .res_valid(res_valid), .res_ready(res_ready), .res_taken(res_taken),
        .res_target(res_target), .update(update), .update_address(update_address),
        .branch_taken(branch_taken), .flush(flush), .redirect_pc(redirect_pc),
        .occupancy(occupancy), .branch_cnt(branch_cnt), .mispred_cnt(mispred_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic        pt;
        logic [31:0] ptgt;
        logic        rt;
        logic [31:0] rtgt;
        logic [7:0]  addr;
        logic        fl;
        logic [31:0] redir;
    } vec_t;

    vec_t vecs [7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_push(input logic [31:0] pc, input logic pt, input logic [31:0] ptgt);
        check("push_ready_before_push", push_ready, 1);
        push_valid = 1'b1; push_pc = pc; push_pred_taken = pt; push_pred_target = ptgt;
        tick();
        push_valid = 1'b0;
    endtask

    task automatic do_resolve(input logic rt, input logic [31:0] rtgt);
        check("res_ready_before_resolve", res_ready, 1);
        res_valid = 1'b1; res_taken = rt; res_target = rtgt;
        tick();
        res_valid = 1'b0;
    endtask

    initial begin
        int exp_br, exp_mp, upd_seen;
        logic [7:0] exp_addr;

        vecs[0] = '{32'h100,      1'b0, 32'h0,    1'b0, 32'h0,    8'h40, 1'b0, 32'h0};
        vecs[1] = '{32'h200,      1'b0, 32'h0,    1'b1, 32'h300,  8'h80, 1'b1, 32'h300};
        vecs[2] = '{32'h10,       1'b1, 32'h80,   1'b1, 32'h90,   8'h04, 1'b1, 32'h90};
        vecs[3] = '{32'h44,       1'b1, 32'h100,  1'b0, 32'h0,    8'h11, 1'b1, 32'h48};
        vecs[4] = '{32'h3FC,      1'b1, 32'h500,  1'b1, 32'h500,  8'hFF, 1'b0, 32'h0};
        vecs[5] = '{32'hFFFFFFFC, 1'b1, 32'h8,    1'b0, 32'h0,    8'hFF, 1'b1, 32'h0};
        vecs[6] = '{32'h1234,     1'b1, 32'h2000, 1'b1, 32'h2000, 8'h8D, 1'b0, 32'h0};

        rst = 1'b1; push_valid = 1'b0; push_pc = '0; push_pred_taken = 1'b0;
        push_pred_target = '0; res_valid = 1'b0; res_taken = 1'b0; res_target = '0;
        tick(); tick();
        rst = 1'b0;
        check("reset_update", update, 0);
        check("reset_flush", flush, 0);
        check("reset_occupancy", occupancy, 0);
        check("reset_branch_cnt", branch_cnt, 0);
        check("reset_redirect", redirect_pc, 0);
        check("reset_push_ready", push_ready, 1);
        check("reset_res_ready", res_ready, 0);

        exp_br = 0; exp_mp = 0;
        foreach (vecs[i]) begin
            do_push(vecs[i].pc, vecs[i].pt, vecs[i].ptgt);
            check("occ_after_push", occupancy, 1);
            do_resolve(vecs[i].rt, vecs[i].rtgt);
            exp_br++;
            if (vecs[i].fl) exp_mp++;
            check("vec_update", update, 1);
            check("vec_addr", update_address, vecs[i].addr);
            check("vec_taken", branch_taken, vecs[i].rt);
            check("vec_flush", flush, vecs[i].fl);
            if (vecs[i].fl) check("vec_redirect", redirect_pc, vecs[i].redir);
            check("vec_occ", occupancy, 0);
            check("vec_branch_cnt", branch_cnt, exp_br);
            check("vec_mispred_cnt", mispred_cnt, exp_mp);
            check("vec_push_ready_t1", push_ready, vecs[i].fl ? 0 : 1);
            tick();
            check("vec_update_drop", update, 0);
            check("vec_flush_drop", flush, 0);
            if (vecs[i].fl) begin
                check("vec_push_ready_t2", push_ready, 0);
                tick();
            end
            check("vec_push_ready_run", push_ready, 1);
        end

        // Fill the queue with push_valid held; pointers wrap here.
        push_valid = 1'b1; push_pred_taken = 1'b0; push_pred_target = '0;
        for (int k = 0; k < 4; k++) begin
            push_pc = 32'h400 + 32'(4 * k);
            tick();
        end
        check("fill_occ", occupancy, 4);
        check("fill_push_ready", push_ready, 0);
        push_pc = 32'h410;
        tick();
        check("fill_hold_occ", occupancy, 4);
        push_valid = 1'b0;

        res_valid = 1'b1; res_taken = 1'b0; res_target = '0;
        upd_seen = 0;
        for (int c = 0; c < 9; c++) begin
            check("b2b_res_ready", res_ready, (c < 8 && c % 2 == 0) ? 1 : 0);
            if (update) begin
                exp_addr = 8'(upd_seen);
                check("b2b_addr", update_address, exp_addr);
                upd_seen++;
            end
            tick();
        end
        res_valid = 1'b0;
        check("b2b_updates", upd_seen, 4);
        check("b2b_occ", occupancy, 0);
        check("b2b_flush", flush, 0);

        // Three queued, oldest mispredicts while a push arrives in the same cycle.
        do_push(32'h500, 1'b1, 32'h600);
        do_push(32'h504, 1'b0, 32'h0);
        do_push(32'h508, 1'b0, 32'h0);
        check("sq_occ3", occupancy, 3);
        push_valid = 1'b1; push_pc = 32'h50C; push_pred_taken = 1'b0;
        res_valid = 1'b1; res_taken = 1'b0; res_target = '0;
        tick();
        push_valid = 1'b0; res_valid = 1'b0;
        check("sq_flush", flush, 1);
        check("sq_redirect", redirect_pc, 32'h504);
        check("sq_occ0", occupancy, 0);
        tick();
        tick();
        check("sq_run_push_ready", push_ready, 1);
        res_valid = 1'b1; res_taken = 1'b0;
        tick();
        check("sq_no_update_empty", update, 0);
        check("sq_res_ready_empty", res_ready, 0);
        do_push(32'h600, 1'b0, 32'h0);
        check("sq_res_ready_after_push", res_ready, 1);
        tick();
        res_valid = 1'b0;
        check("sq_post_update", update, 1);
        check("sq_post_addr", update_address, 8'h80);
        check("sq_post_flush", flush, 0);

        // Simultaneous push and correct resolve leaves occupancy unchanged.
        tick();
        do_push(32'h700, 1'b0, 32'h0);
        push_valid = 1'b1; push_pc = 32'h704; push_pred_taken = 1'b0;
        res_valid = 1'b1; res_taken = 1'b0;
        tick();
        push_valid = 1'b0; res_valid = 1'b0;
        check("ov_occ", occupancy, 1);
        check("ov_addr", update_address, 8'hC0);
        tick();
        do_resolve(1'b0, 32'h0);
        check("ov_addr2", update_address, 8'hC1);
        check("ov_occ0", occupancy, 0);

        // Reset asserted while recovering.
        tick();
        do_push(32'h800, 1'b0, 32'h0);
        do_resolve(1'b1, 32'h900);
        check("rr_flush", flush, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rr_push_ready", push_ready, 1);
        check("rr_branch_cnt", branch_cnt, 0);
        check("rr_mispred_cnt", mispred_cnt, 0);
        check("rr_flush_low", flush, 0);
        check("rr_redirect", redirect_pc, 0);
        check("rr_occ", occupancy, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/branch_resolve_unit.md
Name: branch_resolve_unit

Overview:
- Producer of the gshare predictor's training interface.
- Holds a small in-order queue of in-flight predicted branches pushed by fetch, and pops the head when execute resolves a branch.
- Compares prediction against the actual outcome, then drives the predictor's update pulse, address and outcome.
- On a misprediction it issues a flush and redirect PC to fetch, and squashes all younger queued branches.

Parameters:
- DEPTH, 4, in-flight branch queue entries (power of 2, ≥2)
- PC_W, 32, program counter width
- IDX_W, 8, predictor index width; update_address = pc[IDX_W+1:2]
- FLUSH_CYCLES, 2, cycles spent in RECOVER after a flush (≥1)

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- push_valid  in  1  fetch presents a predicted branch
- push_ready  out  1  queue can accept a branch this cycle
- push_pc  in  PC_W  branch PC
- push_pred_taken  in  1  predicted direction
- push_pred_target  in  PC_W  predicted target (valid when predicted taken)
- res_valid  in  1  execute presents resolution of the oldest branch
- res_ready  out  1  resolution accepted this cycle
- res_taken  in  1  actual direction
- res_target  in  PC_W  actual target
- update  out  1  one-cycle training pulse to predictor
- update_address  out  IDX_W  predictor index of resolved branch
- branch_taken  out  1  actual outcome for predictor training
- flush  out  1  one-cycle squash of younger instructions
- redirect_pc  out  PC_W  correct fetch PC, valid with flush
- occupancy  out  log2(DEPTH)+1  queued branch count
- branch_cnt  out  16  resolved branches, saturating
- mispred_cnt  out  16  mispredictions, saturating

Behaviour:
- Reset (rst=1 at clk edge):
  - queue empty; state RUN.
  - update, flush, branch_taken, update_address and redirect_pc all 0.
  - counters 0; occupancy 0.
  - Reset dominates everything, including mid-RECOVER and a pending push or resolve.
- States: RUN and RECOVER.
  - RUN → RECOVER on an accepted mispredicting resolution.
  - RECOVER lasts exactly FLUSH_CYCLES cycles, then returns to RUN.
- push_ready = (state==RUN) && !full.
  - Push accepted when push_valid && push_ready; the entry is written at the tail at the edge.
- res_ready = (state==RUN) && !empty && !update.
  - The predictor trains on the update edge, so pulses must be separated by ≥1 low cycle.
  - Resolutions are therefore accepted at most every other cycle.
- res_valid with res_ready=0 is not consumed. Execute holds it until accepted.
- Accepted resolution (edge T): pop head. At T+1 (registered, 1-cycle latency):
  - update=1 for exactly one cycle.
  - update_address = head_pc[IDX_W+1:2].
  - branch_taken = res_taken, held until the next accepted resolution.
  - branch_cnt increments, saturating at 0xFFFF.
- Mispredict condition:
  - head_pred_taken != res_taken, or
  - both taken and head_pred_target != res_target.
- On mispredict, additionally at T+1:
  - flush=1 for one cycle.
  - redirect_pc = res_taken ? res_target : head_pc+4 (mod 2^PC_W); holds until the next flush.
  - mispred_cnt increments, saturating.
  - The whole queue is cleared at edge T (occupancy=0 at T+1).
  - State enters RECOVER.
- Simultaneous push and resolve in RUN:
  - Both take effect; occupancy is unchanged.
  - If the resolve mispredicts, the pushed entry is also discarded.
- Push to a full queue is impossible, since push_ready=0 when full.
  - Full with simultaneous pop does not accept a push (push_ready depends only on full, not on the pop).
- During RECOVER: push_ready=0 and res_ready=0; inputs are ignored and no state changes.
- A correct prediction produces update only; flush stays 0 and state stays RUN.
- Queue pointers wrap modulo DEPTH; occupancy runs 0..DEPTH.

Test Plan:
- Reset then push pc=0x100 pred NT; resolve NT.
  - → T+1: update=1, update_address=0x40, branch_taken=0, flush=0.
  - → branch_cnt=1, mispred_cnt=0, occupancy 0.
- Push pc=0x200 pred NT; resolve taken, target 0x300.
  - → T+1: update=1, branch_taken=1, flush=1, redirect_pc=0x300, mispred_cnt=1.
  - → push_ready=0 for 2 cycles, then 1.
- Push pc=0x10 pred T, target 0x80; resolve T, target 0x90.
  - → flush=1, redirect_pc=0x90.
- Push 4 branches (DEPTH=4) with push_valid held high.
  - → push_ready=0 on the 5th cycle, occupancy=4.
  - → resolve all 4 correct back-to-back: res_ready alternates 1,0; four separate update pulses.
- Queue holds 3 entries and the oldest mispredicts.
  - → occupancy 0 next cycle; a push in the same cycle is dropped.
  - → the first post-RECOVER resolve is not accepted until a new push.
- Assert rst during RECOVER.
  - → next cycle state RUN, push_ready=1, all counters 0, flush=0.
